// File: rtl/pipeline_hazard_controller.sv
// Pipeline enable/flush sequencer for a 5-stage pipe: load-use stalls, taken-branch flushes,
// data-memory wait freezes with a timeout-to-HALT, and saturating stall/flush counters.
module pipeline_hazard_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt_dst,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             mem_wb_bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout_err
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W:0] TIMEOUT_W = (WAIT_W + 1)'(MEM_TIMEOUT);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT     = 2'd2;

    logic [1:0]        state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [WAIT_W:0]   wait_inc;
    logic              err_reg, err_set;
    logic              load_use;
    logic              freeze, halt, apply_run;
    logic              flush_inc, stall_inc;
    logic [1:0]        cnt_inc;

    assign load_use = ex_mem_read && (ex_rt_dst != 5'd0) &&
                      ((ex_rt_dst == id_rs) || (id_uses_rt && (ex_rt_dst == id_rt)));

    // One extra bit so the compare against the timeout never sees a wrapped value.
    assign wait_inc = {1'b0, wait_cnt_reg} + (WAIT_W + 1)'(1);

    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        mem_wb_bubble = 1'b0;
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        err_set       = 1'b0;
        flush_inc     = 1'b0;
        freeze        = 1'b0;
        halt          = 1'b0;
        apply_run     = 1'b0;

        if (!rst_n) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (mem_req && !mem_ready) begin
                        freeze        = 1'b1;
                        wait_cnt_next = WAIT_W'(1);
                        if (MEM_TIMEOUT == 1) begin
                            state_next = ST_HALT;
                            err_set    = 1'b1;
                        end else begin
                            state_next = ST_MEM_WAIT;
                        end
                    end else begin
                        apply_run = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!mem_ready) begin
                        freeze        = 1'b1;
                        wait_cnt_next = wait_inc[WAIT_W-1:0];
                        if (wait_inc == TIMEOUT_W) begin
                            state_next = ST_HALT;
                            err_set    = 1'b1;
                        end
                    end else begin
                        apply_run     = 1'b1;
                        state_next    = ST_RUN;
                        wait_cnt_next = '0;
                    end
                end
                ST_HALT: begin
                    halt = 1'b1;
                end
                default: begin
                    state_next    = ST_RUN;
                    wait_cnt_next = '0;
                end
            endcase

            if (freeze || halt) begin
                pc_en         = 1'b0;
                if_id_en      = 1'b0;
                id_ex_en      = 1'b0;
                ex_mem_en     = 1'b0;
                mem_wb_en     = freeze;
                mem_wb_bubble = 1'b1;
            end else if (apply_run) begin
                // A taken branch squashes the dependent instruction, so no stall is needed.
                if (branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    flush_inc   = 1'b1;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_RUN;
            wait_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (err_set) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign mem_timeout_err = err_reg;
    assign stall_inc       = rst_n && !pc_en;
    assign cnt_inc         = {flush_inc, stall_inc};

    // Index 0 counts stall cycles, index 1 counts branch flushes; both saturate.
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_W-1:0] count_reg;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                count_reg <= '0;
            end else if (cnt_inc[gi] && (count_reg != {CNT_W{1'b1}})) begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

    assign stall_count = g_cnt[0].count_reg;
    assign flush_count = g_cnt[1].count_reg;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: hazards, branch flush, memory waits,
// timeout to HALT, reset recovery and counter saturation (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipeline_hazard_controller;

    localparam int CNT_W = 4;

    // Control vector: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_bubble}
    localparam logic [7:0] C_RST    = 8'b0000_0000;
    localparam logic [7:0] C_RUN    = 8'b1101_0110;
    localparam logic [7:0] C_LOAD   = 8'b0001_1110;
    localparam logic [7:0] C_BRANCH = 8'b1111_1110;
    localparam logic [7:0] C_FREEZE = 8'b0000_0011;
    localparam logic [7:0] C_HALT   = 8'b0000_0001;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_rs, id_rt, ex_rt_dst;
    logic             id_uses_rt, ex_mem_read, branch_taken, mem_req, mem_ready;
    logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic             ex_mem_en, mem_wb_en, mem_wb_bubble, mem_timeout_err;
    logic [CNT_W-1:0] stall_count, flush_count;
    logic [7:0]       ctrl;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign ctrl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_bubble};

    pipeline_hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt_dst(ex_rt_dst),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .mem_wb_bubble(mem_wb_bubble),
        .stall_count(stall_count), .flush_count(flush_count),
        .mem_timeout_err(mem_timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_rt_dst = 5'd0;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ctrl", 32'(ctrl), 32'(C_RST));
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_stall", 32'(stall_count), 0);
        chk("rst_flush", 32'(flush_count), 0);
        chk("rst_err", 32'(mem_timeout_err), 0);
        chk("rst_run", 32'(ctrl), 32'(C_RUN));
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #2;
        chk("init_ctrl", 32'(ctrl), 32'(C_RST));
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("idle_run", 32'(ctrl), 32'(C_RUN));
        chk("idle_stall", 32'(stall_count), 0);

        // Load-use on rs: one bubble, then the load moves on
        ex_mem_read = 1'b1; ex_rt_dst = 5'd2; id_rs = 5'd2;
        #1;
        chk("lu_rs", 32'(ctrl), 32'(C_LOAD));
        tick();
        idle();
        #1;
        chk("lu_after", 32'(ctrl), 32'(C_RUN));
        chk("lu_stall", 32'(stall_count), 1);

        // $0 destination and unused rt never stall; used rt does
        ex_mem_read = 1'b1; ex_rt_dst = 5'd0; id_rs = 5'd0;
        #1;
        chk("lu_r0", 32'(ctrl), 32'(C_RUN));
        ex_rt_dst = 5'd5; id_rt = 5'd5; id_rs = 5'd3; id_uses_rt = 1'b0;
        #1;
        chk("lu_rt_unused", 32'(ctrl), 32'(C_RUN));
        id_uses_rt = 1'b1;
        #1;
        chk("lu_rt_used", 32'(ctrl), 32'(C_LOAD));
        ex_mem_read = 1'b0;
        #1;
        chk("lu_no_load", 32'(ctrl), 32'(C_RUN));
        idle();

        // Branch together with load-use: flush wins, no stall
        do_reset();
        branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt_dst = 5'd2; id_rs = 5'd2;
        #1;
        chk("br_lu", 32'(ctrl), 32'(C_BRANCH));
        tick();
        idle();
        #1;
        chk("br_flush_cnt", 32'(flush_count), 1);
        chk("br_stall_cnt", 32'(stall_count), 0);

        // Three wait cycles then ready, with a taken branch at release
        mem_req = 1'b1; mem_ready = 1'b0;
        #1;
        chk("mw_freeze1", 32'(ctrl), 32'(C_FREEZE));
        tick();
        branch_taken = 1'b1;
        #1;
        chk("mw_freeze2", 32'(ctrl), 32'(C_FREEZE));
        tick();
        branch_taken = 1'b0;
        #1;
        chk("mw_freeze3", 32'(ctrl), 32'(C_FREEZE));
        tick();
        mem_ready = 1'b1; branch_taken = 1'b1;
        #1;
        chk("mw_release", 32'(ctrl), 32'(C_BRANCH));
        tick();
        idle();
        #1;
        chk("mw_back_run", 32'(ctrl), 32'(C_RUN));
        chk("mw_stall_cnt", 32'(stall_count), 3);
        chk("mw_flush_cnt", 32'(flush_count), 2);
        chk("mw_err", 32'(mem_timeout_err), 0);

        // Zero-wait access
        mem_req = 1'b1; mem_ready = 1'b1;
        #1;
        chk("zw_ctrl", 32'(ctrl), 32'(C_RUN));
        tick();
        idle();
        #1;
        chk("zw_stall_cnt", 32'(stall_count), 3);

        // Timeout: four wait cycles then HALT
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        tick();
        tick();
        tick();
        #1;
        chk("to_pre_ctrl", 32'(ctrl), 32'(C_FREEZE));
        chk("to_pre_err", 32'(mem_timeout_err), 0);
        tick();
        chk("to_halt_ctrl", 32'(ctrl), 32'(C_HALT));
        chk("to_err", 32'(mem_timeout_err), 1);
        chk("to_stall_cnt", 32'(stall_count), 4);
        mem_ready = 1'b1;
        tick();
        chk("to_held", 32'(ctrl), 32'(C_HALT));
        chk("to_stall_cnt5", 32'(stall_count), 5);
        idle();
        do_reset();

        // Saturation of stall_count during a long HALT
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("sat_stall", 32'(stall_count), (i > 15) ? 15 : i);
        end
        chk("sat_err", 32'(mem_timeout_err), 1);
        idle();
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
